stream_demux_1xn: RTL
=====================

STREAM_DEMUX_1XN -- requirements
Module: stream_demux_1xn

Interface
REQ-001 SHALL have parameter DATA_W, default 8: data width in bits, legal values 1..64.
REQ-002 SHALL have parameter N_CH, default 8: output channel count, legal values 2..16.
REQ-003 SHALL have parameter SEL_W, default $clog2(N_CH): select width.
REQ-004 SHALL have port clk, input, 1: the single clock; all logic samples on the rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port in_data, input, DATA_W: input beat data.
REQ-007 SHALL have port in_valid, input, 1: input beat present.
REQ-008 SHALL have port in_last, input, 1: final beat of packet.
REQ-009 SHALL have port in_sel, input, SEL_W: destination channel, sampled on the first beat of a packet only.
REQ-010 SHALL have port in_ready, output, 1: the block accepts the beat this cycle.
REQ-011 SHALL have port out_data, output, N_CH*DATA_W: channel k occupies bits [k*DATA_W +: DATA_W].
REQ-012 SHALL have port out_valid, output, N_CH: per-channel beat present.
REQ-013 SHALL have port out_last, output, N_CH: per-channel last flag.
REQ-014 SHALL have port out_ready, input, N_CH: per-channel sink ready.
REQ-015 SHALL have port drop_cnt, output, 16: dropped-beat count; present only with DEMUX_DROP_CNT_EN.

Function
REQ-016 SHALL transfer a beat on any port only when valid and ready are both high in the same cycle.
REQ-017 SHALL hold one register slot per channel (data, last, valid).
REQ-018 SHALL route each beat to exactly one channel; out_valid of every other channel SHALL be unaffected.
REQ-019 SHALL implement an FSM with states IDLE and PKT.
- IDLE: the first accepted beat latches in_sel into cur_sel.
- A first beat with in_last=0 moves the FSM to PKT; a first beat with in_last=1 leaves it in IDLE.
- PKT: in_sel is ignored and beats route to cur_sel; acceptance of a beat with in_last=1 returns the FSM to IDLE.
REQ-020 SHALL drive in_ready = !slot_valid[dst] || out_ready[dst]. dst is in_sel in IDLE and cur_sel in PKT. Slot full and drained in the same cycle SHALL accept the new beat without a bubble.
REQ-021 SHALL have a latency of one cycle: a beat accepted at edge n is visible on its channel's out_* after edge n.
REQ-022 SHALL clear slot_valid on out_valid&&out_ready when no new beat is loaded into that slot.
REQ-023 SHALL treat in_sel >= N_CH on a first beat as invalid.
- The whole packet is dropped: in_ready=1 and no channel is written.
- The FSM still tracks in_last.
REQ-024 SHALL keep out_valid of a channel stable until that channel's out_ready; a full slot SHALL never be overwritten.
REQ-025 SHALL keep out_data/out_last stable while out_valid is high and out_ready is low.
REQ-026 SHALL leave out_data of empty slots at their last value; output is don't-care when out_valid=0.

Reset
REQ-027 SHALL, on rst_n low, immediately and asynchronously clear:
- out_valid and out_last to 0, out_data to 0;
- FSM to IDLE, cur_sel to 0, drop_cnt to 0.
REQ-028 SHALL discard any partially transferred packet on reset mid-packet; after release, the next beat is treated as a first beat.
REQ-029 SHALL drive in_ready per REQ-020 after release; no extra wait cycle is required.

Configuration
REQ-030 SHALL, with DEMUX_DROP_CNT_EN defined, provide drop_cnt.
- It increments by 1 per beat dropped under REQ-023.
- It saturates at 16'hFFFF.
REQ-031 SHALL, without DEMUX_DROP_CNT_EN, omit the drop_cnt port and counter; dropped beats are still discarded silently.

Verification
REQ-032 SHALL cover single-beat routing: N_CH=8, in_sel=3, in_data=8'hA5, in_last=1, all out_ready=1 -> next cycle out_valid=8'b0000_1000, channel 3 data 8'hA5, out_last[3]=1.
REQ-033 SHALL cover packet lock: 3-beat packet, in_sel=2 then in_sel changes to 5 on beats 2-3 -> all three beats on channel 2, FSM back in IDLE after beat 3.
REQ-034 SHALL cover backpressure: out_ready[1]=0, two beats to channel 1 -> first held stable, in_ready=0 on second; raise out_ready[1] -> second accepted the same cycle, no bubble.
REQ-035 SHALL cover channel independence: channel 0 stalled full, packet to channel 4 -> channel 4 proceeds, channel 0 content unchanged.
REQ-036 SHALL cover invalid select: N_CH=6, in_sel=7, 4-beat packet -> in_ready=1 throughout, no out_valid, drop_cnt=4 (macro on).
REQ-037 SHALL cover reset mid-packet: rst_n low during beat 2 of a packet -> out_valid=0 at once; after release, in_sel is resampled on the next beat.

Source files
------------

// File: rtl/stream_demux_1xn.sv
// stream_demux_1xn: 1-to-N packet stream demultiplexer with one register
// slot per output channel. The destination is chosen by in_sel on the first
// beat of a packet and held until the beat carrying in_last is accepted.
// Packets addressed to a channel that does not exist are accepted and
// discarded.
//
// Optional feature: define DEMUX_DROP_CNT_EN to add the 16-bit saturating
// drop_cnt output, which counts the discarded beats.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | waiting for the first beat of a packet; in_sel picks the channel
// PKT   | inside a packet; beats follow cur_sel, in_sel is ignored
module stream_demux_1xn #(
    parameter int DATA_W = 8,
    parameter int N_CH   = 8,
    parameter int SEL_W  = $clog2(N_CH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_valid,
    input  logic                     in_last,
    input  logic [SEL_W-1:0]         in_sel,
    output logic                     in_ready,
    output logic [N_CH*DATA_W-1:0]   out_data,
    output logic [N_CH-1:0]          out_valid,
    output logic [N_CH-1:0]          out_last,
    input  logic [N_CH-1:0]          out_ready
`ifdef DEMUX_DROP_CNT_EN
    ,
    output logic [15:0]              drop_cnt
`endif
);

    typedef enum logic [0:0] {IDLE, PKT} state_t;

    // N_CH widened by one bit so a full-range in_sel can be compared against it
    localparam logic [SEL_W:0] N_CH_X = (SEL_W+1)'(N_CH);

    state_t             state;
    logic [SEL_W-1:0]   cur_sel;
    logic               drop_pkt;

    logic [SEL_W-1:0]   dst;
    logic               sel_ok;
    logic               drop_now;
    logic               dst_free;
    logic               accept;
    logic [N_CH-1:0]    wr;

    // Destination decode, ready generation and per-slot write enables
    always_comb begin
        dst      = (state == PKT) ? cur_sel : in_sel;
        sel_ok   = ({1'b0, in_sel} < N_CH_X);
        drop_now = (state == PKT) ? drop_pkt : !sel_ok;
        dst_free = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            if (dst == SEL_W'(k)) begin
                // a full slot that drains this cycle can take the new beat
                dst_free = !out_valid[k] || out_ready[k];
            end
        end
        // beats of a dropped packet are always swallowed
        in_ready = drop_now || dst_free;
        accept   = in_valid && in_ready;
        wr       = '0;
        for (int k = 0; k < N_CH; k++) begin
            wr[k] = accept && !drop_now && (dst == SEL_W'(k));
        end
    end

    // Packet framing FSM: latch destination on the first beat, release on last
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cur_sel  <= '0;
            drop_pkt <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cur_sel  <= in_sel;
                        drop_pkt <= !sel_ok;
                        if (!in_last) begin
                            state <= PKT;
                        end
                    end
                end
                PKT: begin
                    if (accept && in_last) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Per-channel output slots: load on write, empty when drained
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_valid <= '0;
            out_last  <= '0;
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                if (wr[k]) begin
                    out_data[k*DATA_W +: DATA_W] <= in_data;
                    out_last[k]                  <= in_last;
                    out_valid[k]                 <= 1'b1;
                end else if (out_valid[k] && out_ready[k]) begin
                    out_valid[k] <= 1'b0;
                end
            end
        end
    end

`ifdef DEMUX_DROP_CNT_EN
    // Saturating count of beats discarded for an out-of-range destination
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (accept && drop_now && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end
`endif

endmodule
